// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle sequencer for the 16-bit stack CPU datapath.
// Decodes ir[15:11] and issues strobes, mux selects and memory handshakes.
//   state  | meaning
//   IDLE   | waiting for start, all outputs quiet
//   FETCH  | read instruction at PC, ld_ir when memory answers
//   DECODE | one cycle to route on opcode
//   MEM    | single data access at SP / SP-1 until mem_ready
//   EXEC   | write-back strobes, retire instruction
//   HALT   | parked until reset
module cpu_seq_ctrl #(
  parameter int          CNT_W    = 16,
  parameter logic [4:0]  HALT_OPC = 5'b11111
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      ir,
  input  logic             cond_true,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       addr_src,
  output logic             data_src,
  output logic             ld_ir,
  output logic             ld_pc,
  output logic             ld_sp,
  output logic             ld_reg,
  output logic             ld_flg,
  output logic [1:0]       pc_src,
  output logic             sp_dec,
  output logic [2:0]       alu_func,
  output logic [3:0]       cond_sel,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM, S_EXEC, S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [4:0] opc;
  logic is_halt, is_push, is_pop, is_alu, is_jmp, is_call, is_ret;
  logic is_mem, is_write, is_illegal;
  logic unused_ir;

  assign opc       = ir[15:11];
  assign unused_ir = ^ir[6:0];

  // HALT_OPC is checked first so a remapped halt code still wins over any class
  assign is_halt    = (opc == HALT_OPC);
  assign is_push    = !is_halt && (opc == 5'b00000);
  assign is_pop     = !is_halt && (opc == 5'b00001);
  assign is_alu     = !is_halt && (opc[4:3] == 2'b01);
  assign is_jmp     = !is_halt && (opc == 5'b10000);
  assign is_call    = !is_halt && (opc == 5'b10001);
  assign is_ret     = !is_halt && (opc == 5'b10010);
  assign is_mem     = is_push || is_pop || is_alu || is_call || is_ret;
  assign is_write   = is_push || is_call;
  assign is_illegal = !is_halt && !is_mem && !is_jmp;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (is_halt)     state_d = S_HALT;
        else if (is_mem) state_d = S_MEM;
        else             state_d = S_EXEC;
      end
      S_MEM:    if (mem_ready) state_d = S_EXEC;
      S_EXEC: begin
        state_d   = S_FETCH;
        retired_d = retired_q + 1'b1;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addr_src = 2'd0;
    data_src = 1'b0;
    ld_ir    = 1'b0;
    ld_pc    = 1'b0;
    ld_sp    = 1'b0;
    ld_reg   = 1'b0;
    ld_flg   = 1'b0;
    pc_src   = 2'd0;
    sp_dec   = 1'b0;
    alu_func = 3'd0;
    cond_sel = (state_q == S_IDLE) ? 4'd0 : ir[10:7];
    halted   = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        ld_ir   = mem_ready;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = is_write;
        addr_src = is_write ? 2'd2 : 2'd1;
        data_src = is_call;
      end
      S_EXEC: begin
        ld_pc = 1'b1;
        if (is_push) begin
          ld_sp  = 1'b1;
          sp_dec = 1'b1;
        end
        if (is_pop) begin
          ld_reg = 1'b1;
          ld_sp  = 1'b1;
        end
        if (is_alu) begin
          alu_func = opc[2:0];
          ld_reg   = 1'b1;
          ld_flg   = 1'b1;
        end
        if (is_jmp)  pc_src = cond_true ? 2'd1 : 2'd0;
        if (is_call) begin
          pc_src = 2'd1;
          ld_sp  = 1'b1;
          sp_dec = 1'b1;
        end
        if (is_ret) begin
          pc_src = 2'd2;
          ld_sp  = 1'b1;
        end
        illegal = is_illegal;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: a table of instructions walked through
// FETCH/DECODE/MEM/EXEC, plus hand sequences for halt and mid-handshake reset.
module tb_cpu_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset, start, cond_true, mem_ready;
  logic [15:0] ir;
  logic        mem_req, mem_we, data_src, ld_ir, ld_pc, ld_sp, ld_reg, ld_flg;
  logic        sp_dec, halted, illegal;
  logic [1:0]  addr_src, pc_src;
  logic [2:0]  alu_func;
  logic [3:0]  cond_sel;
  logic [15:0] retired;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_retired = 0;

  cpu_seq_ctrl #(.CNT_W(16), .HALT_OPC(5'b11111)) dut (
    .clock(clock), .reset(reset), .start(start), .ir(ir),
    .cond_true(cond_true), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src),
    .data_src(data_src), .ld_ir(ld_ir), .ld_pc(ld_pc), .ld_sp(ld_sp),
    .ld_reg(ld_reg), .ld_flg(ld_flg), .pc_src(pc_src), .sp_dec(sp_dec),
    .alu_func(alu_func), .cond_sel(cond_sel), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] ir;
    logic        cond;
    int          wait_n;
    logic        memc;
    logic        wr;
    logic [1:0]  asrc;
    logic        dsrc;
    logic [1:0]  psrc;
    logic        ld_sp;
    logic        spd;
    logic        ld_reg;
    logic        ld_flg;
    logic [2:0]  alu;
    logic        ill;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {mem_req, mem_we, addr_src, data_src, ld_ir, ld_pc, ld_sp, ld_reg,
            ld_flg, pc_src, sp_dec, alu_func, cond_sel, halted, illegal};
  endfunction

  // Entered just after a negedge with the DUT in FETCH; leaves it in the next FETCH.
  task automatic run_vec(input vec_t v);
    logic [15:0] iw;
    iw = v.ir;
    mem_ready = 1'b1; ir = v.ir; cond_true = v.cond; #1;
    chk("fetch_req",  mem_req, 1);
    chk("fetch_we",   mem_we, 0);
    chk("fetch_addr", addr_src, 0);
    chk("fetch_ldir", ld_ir, 1);
    chk("fetch_ill",  illegal, 0);
    @(negedge clock); #1;
    chk("dec_req",     mem_req, 0);
    chk("dec_strobes", {ld_ir, ld_pc, ld_sp, ld_reg, ld_flg, illegal}, 0);
    chk("dec_cond",    cond_sel, iw[10:7]);
    @(negedge clock);
    if (v.memc) begin
      for (int i = 0; i <= v.wait_n; i++) begin
        mem_ready = (i == v.wait_n); #1;
        chk("mem_req",     mem_req, 1);
        chk("mem_we",      mem_we, v.wr);
        chk("mem_addr",    addr_src, v.asrc);
        chk("mem_dsrc",    data_src, v.dsrc);
        chk("mem_strobes", {ld_ir, ld_pc, ld_sp, ld_reg, ld_flg, illegal}, 0);
        @(negedge clock);
      end
    end
    mem_ready = 1'b1; #1;
    chk("exec_req",   mem_req, 0);
    chk("exec_ldir",  ld_ir, 0);
    chk("exec_ldpc",  ld_pc, 1);
    chk("exec_pcsrc", pc_src, v.psrc);
    chk("exec_ldsp",  ld_sp, v.ld_sp);
    chk("exec_spdec", sp_dec, v.spd);
    chk("exec_ldreg", ld_reg, v.ld_reg);
    chk("exec_ldflg", ld_flg, v.ld_flg);
    chk("exec_alu",   alu_func, v.alu);
    chk("exec_ill",   illegal, v.ill);
    @(negedge clock);
    exp_retired++; #1;
    chk("retired", retired, exp_retired);
  endtask

  initial begin
    //         ir        cond wait memc wr asrc dsrc psrc sp spd reg flg alu   ill
    vecs[0] = '{16'h0200, 0, 0, 1, 1, 2'd2, 0, 2'd0, 1, 1, 0, 0, 3'b000, 0}; // PUSH
    vecs[1] = '{16'h5300, 0, 2, 1, 0, 2'd1, 0, 2'd0, 0, 0, 1, 1, 3'b010, 0}; // ALU 010
    vecs[2] = '{16'h8283, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 3'b000, 0}; // JMP not taken
    vecs[3] = '{16'h8283, 1, 0, 0, 0, 2'd0, 0, 2'd1, 0, 0, 0, 0, 3'b000, 0}; // JMP taken
    vecs[4] = '{16'h8805, 0, 0, 1, 1, 2'd2, 1, 2'd1, 1, 1, 0, 0, 3'b000, 0}; // CALL
    vecs[5] = '{16'h9000, 0, 1, 1, 0, 2'd1, 0, 2'd2, 1, 0, 0, 0, 3'b000, 0}; // RET
    vecs[6] = '{16'h0D00, 0, 1, 1, 0, 2'd1, 0, 2'd0, 1, 0, 1, 0, 3'b000, 0}; // POP
    vecs[7] = '{16'hC000, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 3'b000, 1}; // illegal 11000
    vecs[8] = '{16'h7800, 0, 0, 1, 0, 2'd1, 0, 2'd0, 0, 0, 1, 1, 3'b111, 0}; // ALU 111
    vecs[9] = '{16'h1000, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 3'b000, 1}; // illegal 00010

    reset = 1'b1; start = 1'b0; ir = 16'h0; cond_true = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_outs",    all_outs(), 0);
    chk("rst_retired", retired, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) begin
      #1 chk("idle_outs", all_outs(), 0);
      @(negedge clock);
    end
    start = 1'b1; #1;
    chk("idle_start_outs", all_outs(), 0);
    @(negedge clock);
    start = 1'b0;
    // FETCH stalls until memory answers
    mem_ready = 1'b0; ir = 16'h0200; #1;
    chk("fetch_hold_req",  mem_req, 1);
    chk("fetch_hold_ldir", ld_ir, 0);
    @(negedge clock);

    for (int k = 0; k < 10; k++) run_vec(vecs[k]);

    // HALT: parked regardless of start, not counted
    ir = 16'hF800; mem_ready = 1'b1; #1;
    chk("halt_fetch_ldir", ld_ir, 1);
    @(negedge clock); #1;
    chk("halt_dec_halted", halted, 0);
    @(negedge clock);
    for (int i = 0; i < 20; i++) begin
      start = i[0]; mem_ready = i[1]; #1;
      chk("halt_halted",  halted, 1);
      chk("halt_req",     mem_req, 0);
      chk("halt_retired", retired, exp_retired);
      @(negedge clock);
    end
    start = 1'b0;

    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; exp_retired = 0; #1;
    chk("halt_exit_outs",    all_outs(), 0);
    chk("halt_exit_retired", retired, 0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    run_vec(vecs[0]);

    // reset in the middle of a MEM handshake
    ir = 16'h0D00; mem_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    mem_ready = 1'b0; #1;
    chk("midrst_mem_req", mem_req, 1);
    reset = 1'b1;
    @(negedge clock); #1;
    chk("midrst_outs",    all_outs(), 0);
    chk("midrst_retired", retired, 0);
    reset = 1'b0; mem_ready = 1'b1;
    @(negedge clock); #1;
    chk("midrst_idle_outs", all_outs(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Multi-cycle control FSM that sequences the 16-bit stack CPU datapath: PC, SP, 8-entry register bank, 3-bit-function ALU, flag register, condition selector and a shared single-port memory.
- Fetches each instruction, decodes IR, and issues load strobes, mux selects and memory handshakes one state at a time.
- Replaces the single-state controller; the datapath stays purely structural.

Parameters:
CNT_W, 16, width of retired-instruction counter
HALT_OPC, 5'b11111, opcode that halts the sequencer

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  leave IDLE and begin fetching
ir  in  16  instruction register contents (valid from DECODE on)
cond_true  in  1  output of status condition selector for cond = ir[10:7]
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request
mem_we  out  1  1 = write, 0 = read (valid while mem_req)
addr_src  out  2  0 = PC, 1 = SP, 2 = SP-1
data_src  out  1  write data: 0 = register bank, 1 = PC+1
ld_ir, ld_pc, ld_sp, ld_reg, ld_flg  out  1 each  single-cycle load strobes
pc_src  out  2  0 = PC+1, 1 = PC+1+sext(ir[6:0]), 2 = memory data
sp_dec  out  1  SP update: 1 = SP-1, 0 = SP+1
alu_func  out  3  ALU function select
cond_sel  out  4  = ir[10:7] (condition index)
halted  out  1  high in HALT
illegal  out  1  one-cycle pulse on undefined opcode
retired  out  CNT_W  instructions completed

Behaviour:
- Reset (synchronous, active-high; clock is clock): state <= IDLE, retired <= 0. All strobes, mem_req, illegal, halted = 0. Reset dominates every state, including mid-handshake; mem_req drops the cycle after the reset edge.
- States: IDLE, FETCH, DECODE, MEM, EXEC, HALT. Outputs are Moore-decoded from the state and ir[15:11].
- IDLE: all outputs 0; start=1 -> FETCH.
- FETCH: mem_req=1, mem_we=0, addr_src=0. Hold until mem_ready; in that cycle ld_ir=1, then -> DECODE.
- DECODE: 1 cycle, no strobes. Memory-class opcodes -> MEM; JMP and illegal -> EXEC; HALT_OPC -> HALT.
- MEM: mem_req=1 held until mem_ready (minimum 1 cycle, no timeout), then -> EXEC. mem_ready is ignored outside FETCH and MEM.
- EXEC: 1 cycle, issues the write-back strobes, retired += 1 (wraps), -> FETCH.
- Opcodes (ir[15:11]; reg = ir[10:8]):
  - 00000 PUSH: MEM write, addr_src=2, data_src=0. EXEC: ld_sp with sp_dec=1; ld_pc with pc_src=0.
  - 00001 POP: MEM read, addr_src=1. EXEC: ld_reg; ld_sp with sp_dec=0; ld_pc with pc_src=0.
  - 01fff ALU: MEM read at SP. EXEC: alu_func=fff, ld_reg, ld_flg, ld_pc with pc_src=0. Reg <= f(Reg, M[SP]).
  - 10000 JMP: EXEC: ld_pc with pc_src = cond_true ? 1 : 0. cond_true is sampled in the EXEC cycle.
  - 10001 CALL: MEM write, addr_src=2, data_src=1. EXEC: ld_sp with sp_dec=1; ld_pc with pc_src=1.
  - 10010 RET: MEM read at SP. EXEC: ld_pc with pc_src=2; ld_sp with sp_dec=0.
  - HALT_OPC: -> HALT; halted=1; exit only by reset. Not counted in retired.
  - All others: illegal=1 in EXEC, treated as NOP: ld_pc with pc_src=0, counted in retired.
- alu_func=000 and cond_sel=ir[10:7] outside ALU EXEC; ld_flg only in ALU EXEC.
- At most one memory request per state. mem_we never changes while mem_req is held.

Test Plan:
- Reset then start=1 with mem_ready tied high, ir=PUSH -> FETCH/DECODE/MEM/EXEC = 4 cycles; mem_we=1 and addr_src=2 in MEM; ld_sp with sp_dec=1 in EXEC; retired=1.
- ALU opcode 01010 with mem_ready delayed 3 cycles in MEM -> mem_req held 3 cycles; EXEC has alu_func=010 and ld_reg=ld_flg=ld_pc=1.
- JMP with cond_true=0 then 1 -> pc_src=0, then pc_src=1; no mem_req in either MEM window; retired increments by 2.
- CALL then RET -> CALL: write with data_src=1, addr_src=2, sp_dec=1. RET: read at addr_src=1, pc_src=2, sp_dec=0.
- Opcode 11000 -> illegal pulses exactly 1 cycle, pc_src=0. Opcode 11111 -> halted=1 and stays there through 20 cycles of start toggling.
- Assert reset while in MEM with mem_req=1 and mem_ready=0 -> next cycle state IDLE, all outputs 0, retired=0.
